// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared segment types and glyph constants for the hex display bank
//
// Purpose: active-low seven-segment glyphs, bit order {g,f,e,d,c,b,a}.
// Ports:   none (package).
package hex_display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0      = 7'b1000000;
  localparam seg_t SEG_1      = 7'b1111001;
  localparam seg_t SEG_2      = 7'b0100100;
  localparam seg_t SEG_3      = 7'b0110000;
  localparam seg_t SEG_4      = 7'b0011001;
  localparam seg_t SEG_5      = 7'b0010010;
  localparam seg_t SEG_6      = 7'b0000010;
  localparam seg_t SEG_7      = 7'b1111000;
  localparam seg_t SEG_8      = 7'b0000000;
  localparam seg_t SEG_9      = 7'b0010000;
  localparam seg_t SEG_A      = 7'b0001000;
  localparam seg_t SEG_B      = 7'b0000011;
  localparam seg_t SEG_C      = 7'b1000110;
  localparam seg_t SEG_D      = 7'b0100001;
  localparam seg_t SEG_E      = 7'b0000110;
  localparam seg_t SEG_F      = 7'b0001110;
  localparam seg_t SEG_BLANK  = 7'h7F;
  localparam seg_t SEG_ALL_ON = 7'h00;

endpackage

// File: rtl/hex_glyph.sv
// rtl/hex_glyph.sv - combinational nibble to active-low seven-segment decoder
//
// Purpose: maps one hex nibble to its glyph.
// Ports:
//   i_nibble  in  4  hex digit value
//   o_seg     out 7  active-low segments {g,f,e,d,c,b,a}
module hex_glyph
  import hex_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_t       o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_bank.sv
// rtl/hex_display_bank.sv - multi-digit active-low seven-segment driver with blink, suppression and lamp test
//
// Purpose: captures a packed hex value on load_i and drives NUM_DIGITS registered
//          segment buses with leading-zero suppression, per-digit blink and lamp test.
// Configuration macro: HEX_DISPLAY_BLINK_EN (defined: blink counter, phase and mask exist;
//          undefined: blink_mask_i is ignored and digits never blink).
// Ports:
//   clk           in  1             system clock
//   rst_n         in  1             asynchronous active-low reset
//   load_i        in  1             capture strobe for value_i / blink_mask_i
//   value_i       in  4*NUM_DIGITS  packed nibbles, nibble 0 rightmost
//   blink_mask_i  in  NUM_DIGITS    per-digit blink enable
//   lz_en_i       in  1             leading-zero suppression (live)
//   lamp_test_i   in  1             force all segments on (live)
//   hex_o         out 7*NUM_DIGITS  registered active-low segments per digit
module hex_display_bank
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   blink_mask_i,
  input  logic                    lz_en_i,
  input  logic                    lamp_test_i,
  output logic [7*NUM_DIGITS-1:0] hex_o
);

  logic [4*NUM_DIGITS-1:0] r_value;
  logic [7*NUM_DIGITS-1:0] r_hex;
  logic [7*NUM_DIGITS-1:0] w_hex_next;
  logic [NUM_DIGITS-1:0]   w_blink_off;
  logic [NUM_DIGITS-1:0]   w_zero_from;
  seg_t                    w_glyph [NUM_DIGITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (load_i) begin
      r_value <= value_i;
    end
  end

`ifdef HEX_DISPLAY_BLINK_EN
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [NUM_DIGITS-1:0] r_mask;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_phase;
  logic                  w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(BLINK_DIV - 1));

  // Counter and phase run freely; loads never touch them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask  <= '0;
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else begin
      if (load_i) begin
        r_mask <= blink_mask_i;
      end
      if (w_wrap) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_blink_off = r_phase ? '0 : r_mask;
`else
  logic w_unused_mask;
  assign w_unused_mask = ^blink_mask_i;
  assign w_blink_off   = '0;
`endif

  // w_zero_from[n]: nibbles n..NUM_DIGITS-1 of the captured value are all zero.
  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
      hex_glyph u_glyph (
        .i_nibble (r_value[4*g +: 4]),
        .o_seg    (w_glyph[g])
      );
      if (g == NUM_DIGITS - 1) begin : g_top
        assign w_zero_from[g] = (r_value[4*g +: 4] == 4'h0);
      end else begin : g_chain
        assign w_zero_from[g] = (r_value[4*g +: 4] == 4'h0) && w_zero_from[g+1];
      end
    end
  endgenerate

  always_comb begin
    w_hex_next = '1;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (lamp_test_i) begin
        w_hex_next[7*n +: 7] = SEG_ALL_ON;
      end else if (w_blink_off[n]) begin
        w_hex_next[7*n +: 7] = SEG_BLANK;
      end else if (lz_en_i && (n != 0) && w_zero_from[n]) begin
        // Digit 0 is exempt so a zero value still shows one "0".
        w_hex_next[7*n +: 7] = SEG_BLANK;
      end else begin
        w_hex_next[7*n +: 7] = w_glyph[n];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hex <= '1;
    end else begin
      r_hex <= w_hex_next;
    end
  end

  assign hex_o = r_hex;

endmodule

// File: tb/tb_hex_display_bank.sv
// tb/tb_hex_display_bank.sv - self-checking bench for hex_display_bank against a behavioural model
module tb_hex_display_bank;

  localparam int ND = 6;
  localparam int BD = 4;
`ifdef HEX_DISPLAY_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          load_i = 1'b0;
  logic [23:0]   value_i = '0;
  logic [5:0]    blink_mask_i = '0;
  logic          lz_en_i = 1'b0;
  logic          lamp_test_i = 1'b0;
  logic [41:0]   hex_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hex_display_bank #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load_i),
    .value_i      (value_i),
    .blink_mask_i (blink_mask_i),
    .lz_en_i      (lz_en_i),
    .lamp_test_i  (lamp_test_i),
    .hex_o        (hex_o)
  );

  logic [6:0] glyph_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [41:0] ref_display(logic [23:0] v, logic [5:0] m, bit phase_on,
                                              bit lz, bit lt);
    logic [41:0] r;
    r = '1;
    for (int n = 0; n < ND; n++) begin
      if (lt)
        r[7*n +: 7] = 7'b0000000;
      else if (BLINK_ON && !phase_on && m[n])
        r[7*n +: 7] = 7'b1111111;
      else if (lz && n >= 1 && (v >> (4*n)) == 0)
        r[7*n +: 7] = 7'b1111111;
      else
        r[7*n +: 7] = glyph_tbl[(v >> (4*n)) & 24'hF];
    end
    return r;
  endfunction

  // Model: phase is "on" during even multiples of BD edges since reset.
  logic [23:0] m_value;
  logic [5:0]  m_mask;
  int          m_edges;
  logic [41:0] m_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_value <= '0;
      m_mask  <= '0;
      m_edges <= 0;
      m_exp   <= '1;
    end else begin
      m_exp <= ref_display(m_value, m_mask, ((m_edges / BD) % 2) == 0, lz_en_i, lamp_test_i);
      if (load_i) begin
        m_value <= value_i;
        m_mask  <= blink_mask_i;
      end
      m_edges <= m_edges + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (hex_o !== 42'h3FF_FFFF_FFFF) begin
      errors++;
      $display("FAIL reset_blank hex_o=%h expected=%h", hex_o, 42'h3FF_FFFF_FFFF);
    end
    lz_en_i = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (hex_o !== {6{7'b1000000}}) begin
      errors++;
      $display("FAIL reset_first_glyph hex_o=%h expected=%h", hex_o, {6{7'b1000000}});
    end
  endtask

  task automatic test_load_values();
    logic [41:0] exp;
    blink_mask_i = '0;
    lz_en_i = 1'b0;
    value_i = 24'h00123A;
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    tick();
    exp = {7'b1000000, 7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0001000};
    checks++;
    if (hex_o !== exp) begin
      errors++;
      $display("FAIL load_123A hex_o=%h expected=%h", hex_o, exp);
    end
    lz_en_i = 1'b1;
    tick();
    exp = {7'b1111111, 7'b1111111, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0001000};
    checks++;
    if (hex_o !== exp) begin
      errors++;
      $display("FAIL lz_123A hex_o=%h expected=%h", hex_o, exp);
    end
    value_i = 24'h0;
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    tick();
    exp = {{5{7'b1111111}}, 7'b1000000};
    checks++;
    if (hex_o !== exp) begin
      errors++;
      $display("FAIL lz_zero hex_o=%h expected=%h", hex_o, exp);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      load_i = ($urandom_range(0, 2) == 0);
      // Bias towards small values so suppression boundaries get exercised.
      value_i = $urandom() >> ($urandom_range(0, 7) * 4);
      value_i = value_i & 24'hFF_FFFF;
      blink_mask_i = 6'($urandom());
      lz_en_i = $urandom_range(0, 1);
      lamp_test_i = ($urandom_range(0, 9) == 0);
      tick();
      checks++;
      if (hex_o !== m_exp) begin
        errors++;
        $display("FAIL random[%0d] hex_o=%h expected=%h", i, hex_o, m_exp);
      end
    end
    load_i = 1'b0;
    lamp_test_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    load_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      value_i = 24'($urandom());
      blink_mask_i = 6'($urandom());
      lz_en_i = i[0];
      tick();
      checks++;
      if (hex_o !== m_exp) begin
        errors++;
        $display("FAIL back_to_back[%0d] hex_o=%h expected=%h", i, hex_o, m_exp);
      end
    end
    load_i = 1'b0;
  endtask

  task automatic test_blink();
    logic [6:0] prev_d0;
    int last_change;
    int changes;
    blink_mask_i = 6'b000001;
    value_i = 24'h000001;
    lz_en_i = 1'b0;
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    tick();
    prev_d0 = hex_o[6:0];
    last_change = -1;
    changes = 0;
    for (int i = 0; i < 32; i++) begin
      // Mid-period reload must not move the toggle edges.
      load_i = (i == 9);
      tick();
      checks++;
      if (hex_o !== m_exp) begin
        errors++;
        $display("FAIL blink_model[%0d] hex_o=%h expected=%h", i, hex_o, m_exp);
      end
      checks++;
      if (hex_o[41:7] !== {5{7'b1000000}}) begin
        errors++;
        $display("FAIL blink_steady[%0d] upper=%h expected=%h", i, hex_o[41:7], {5{7'b1000000}});
      end
      checks++;
      if (hex_o[6:0] !== 7'b1111001 && hex_o[6:0] !== 7'b1111111) begin
        errors++;
        $display("FAIL blink_glyph[%0d] digit0=%b expected 1111001 or 1111111", i, hex_o[6:0]);
      end
      if (hex_o[6:0] !== prev_d0) begin
        if (last_change >= 0) begin
          checks++;
          if (i - last_change != BD) begin
            errors++;
            $display("FAIL blink_period interval=%0d expected=%0d", i - last_change, BD);
          end
        end
        last_change = i;
        changes++;
        prev_d0 = hex_o[6:0];
      end
    end
    load_i = 1'b0;
    checks++;
    if (changes < 6) begin
      errors++;
      $display("FAIL blink_toggles count=%0d expected>=6", changes);
    end
  endtask

  task automatic test_lamp();
    int guard;
    lz_en_i = 1'b1;
    guard = 0;
    // Land in a blink-off half-period when blinking exists.
    while (BLINK_ON && hex_o[6:0] !== 7'b1111111 && guard < 20) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      errors++;
      $display("FAIL lamp_wait_blink_off timeout guard=%0d expected<20", guard);
    end
    lamp_test_i = 1'b1;
    tick();
    checks++;
    if (hex_o !== 42'h0) begin
      errors++;
      $display("FAIL lamp_on hex_o=%h expected=%h", hex_o, 42'h0);
    end
    lamp_test_i = 1'b0;
    tick();
    checks++;
    if (hex_o !== m_exp) begin
      errors++;
      $display("FAIL lamp_release hex_o=%h expected=%h", hex_o, m_exp);
    end
  endtask

  task automatic test_async_reset();
    value_i = 24'hABCDEF;
    blink_mask_i = 6'b101010;
    lz_en_i = 1'b0;
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (hex_o !== 42'h3FF_FFFF_FFFF) begin
      errors++;
      $display("FAIL async_reset_blank hex_o=%h expected=%h", hex_o, 42'h3FF_FFFF_FFFF);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (hex_o !== {6{7'b1000000}}) begin
      errors++;
      $display("FAIL async_reset_cleared hex_o=%h expected=%h", hex_o, {6{7'b1000000}});
    end
    // Phase restarts "on": a fresh all-digit blink mask stays lit for BD-1 further edges.
    blink_mask_i = 6'b111111;
    value_i = 24'h000005;
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (hex_o !== m_exp) begin
        errors++;
        $display("FAIL post_reset_blink[%0d] hex_o=%h expected=%h", i, hex_o, m_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_values();
    test_random();
    test_back_to_back();
    if (BLINK_ON) test_blink();
    test_lamp();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
